oldland_memarb: RTL

Two-port, round-robin memory bus arbiter that shares one memory bus between the instruction fetch port (`i_*`) and the load/store data port (`d_*`) of the Oldland core. It sits between the fetch and memory pipeline stages and the single bus master interface (`m_*`). It registers each granted request onto the bus and routes the ack, error and read data back to the owning requester. A per-transaction timeout converts a hung slave into a requester error.

---
 rtl/oldland_memarb.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/oldland_memarb.sv
`default_nettype none
// ============================================================================
// Module   : oldland_memarb
// Purpose  : Round-robin arbiter sharing one memory bus between fetch and
//            load/store ports, with a per-transaction timeout.
// Revision : 1.0 - initial release
// ============================================================================
module oldland_memarb #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_access,
    input  logic [29:0] i_addr,
    output logic [31:0] i_data,
    output logic        i_ack,
    output logic        i_error,
    input  logic        d_access,
    input  logic [29:0] d_addr,
    input  logic        d_wr_en,
    input  logic [3:0]  d_bytesel,
    input  logic [31:0] d_wr_val,
    output logic [31:0] d_data,
    output logic        d_ack,
    output logic        d_error,
    output logic        m_access,
    output logic [29:0] m_addr,
    output logic        m_wr_en,
    output logic [3:0]  m_bytesel,
    output logic [31:0] m_wr_val,
    input  logic [31:0] m_data,
    input  logic        m_ack,
    input  logic        m_error,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IBUS = 2'd1,
        DBUS = 2'd2
    } state_t;

    localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [7:0]  count_q, count_d;
    logic [29:0] addr_q, addr_d;
    logic        wr_en_q, wr_en_d;
    logic [3:0]  bytesel_q, bytesel_d;
    logic [31:0] wr_val_q, wr_val_d;

    logic w_busy, w_timeout, w_done, w_fail, w_grant_i, w_grant_d;

    assign w_busy    = (state_q != IDLE);
    assign w_timeout = w_busy && (count_q == c_TO_LAST);
    assign w_done    = w_busy && (m_ack || m_error || w_timeout);
    // An ack always wins over a simultaneous error or timeout.
    assign w_fail    = w_busy && !m_ack && (m_error || w_timeout);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        count_d      = count_q;
        addr_d       = addr_q;
        wr_en_d      = wr_en_q;
        bytesel_d    = bytesel_q;
        wr_val_d     = wr_val_q;
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (d_access && (!i_access || !last_grant_q))
                    w_grant_d = 1'b1;
                else if (i_access)
                    w_grant_i = 1'b1;
            end
            IBUS: begin
                // Only the other port may take over on completion.
                if (w_done) begin
                    if (d_access)
                        w_grant_d = 1'b1;
                    else
                        state_d = IDLE;
                end else begin
                    count_d = count_q + 8'd1;
                end
            end
            DBUS: begin
                if (w_done) begin
                    if (i_access)
                        w_grant_i = 1'b1;
                    else
                        state_d = IDLE;
                end else begin
                    count_d = count_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (w_grant_d) begin
            state_d      = DBUS;
            last_grant_d = 1'b1;
            count_d      = 8'd0;
            addr_d       = d_addr;
            wr_en_d      = d_wr_en;
            bytesel_d    = d_bytesel;
            wr_val_d     = d_wr_val;
        end else if (w_grant_i) begin
            state_d      = IBUS;
            last_grant_d = 1'b0;
            count_d      = 8'd0;
            addr_d       = i_addr;
            wr_en_d      = 1'b0;
            bytesel_d    = 4'hf;
            wr_val_d     = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b0;
            count_q      <= 8'd0;
            addr_q       <= 30'd0;
            wr_en_q      <= 1'b0;
            bytesel_q    <= 4'd0;
            wr_val_q     <= 32'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            count_q      <= count_d;
            addr_q       <= addr_d;
            wr_en_q      <= wr_en_d;
            bytesel_q    <= bytesel_d;
            wr_val_q     <= wr_val_d;
        end
    end

    // Completions arriving while reset is asserted are dropped.
    assign i_ack     = (state_q == IBUS) && m_ack && !rst;
    assign i_error   = (state_q == IBUS) && w_fail && !rst;
    assign d_ack     = (state_q == DBUS) && m_ack && !rst;
    assign d_error   = (state_q == DBUS) && w_fail && !rst;
    assign i_data    = m_data;
    assign d_data    = m_data;
    assign m_access  = w_busy;
    assign busy      = w_busy;
    assign m_addr    = addr_q;
    assign m_wr_en   = wr_en_q;
    assign m_bytesel = bytesel_q;
    assign m_wr_val  = wr_val_q;

endmodule
`default_nettype wire
